game_turn_controller: RTL and testbench
=======================================

# game_turn_controller

Parametrised turn-based game controller for N players on a board of CELLS squares. It owns the board occupancy, the per-turn countdown, move validation, random auto-play on timeout and tie detection. It delegates win detection to an external checker over a req/ack handshake. It sits between the player input front-end and the sprite/print logic of the board games, and replaces the fixed 2-player, 9-cell tic-tac-toe controller.

## Interface
Parameters:
- N_PLAYERS, 2: number of players, legal range 2..15.
- CELLS, 9: number of board squares, legal range 2..256.
- TURN_SECONDS, 15: turn length in sec_tick units, minimum 1.
- Derived, not overridable: IDW = $clog2(N_PLAYERS+1); PW = $clog2(CELLS) (minimum 1); TW = $clog2(TURN_SECONDS+1).

Ports:
- clk, in, 1: single clock. Everything is rising-edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: begins a new game. Honoured only in IDLE or DONE.
- sec_tick, in, 1: one-cycle time-base pulse.
- move_req, in, 1: player move strobe.
- move_pos, in, PW: requested cell.
- win_ack, in, 1: checker response strobe.
- win_flag, in, 1: current player has won. Valid only with win_ack.
- move_ready, out, 1: controller is accepting moves.
- move_reject, out, 1: one-cycle pulse when a move is refused.
- placed, out, 1: one-cycle pulse when a piece is committed.
- placed_pos, out, PW: cell being committed. Valid with placed.
- random_move, out, 1: the commit was automatic. Valid with placed.
- win_req, out, 1: requests a win check. Held until win_ack.
- board, out, CELLS*IDW: cell i is at [i*IDW +: IDW]. 0 means empty, otherwise the owning player.
- cur_player, out, IDW: player to move, 1..N_PLAYERS. 0 in IDLE.
- time_left, out, TW: remaining turn time.
- game_over, out, 1: high in DONE.
- winner, out, IDW: winning player. 0 means tie. Valid with game_over.

## Operation
- States: IDLE, WAIT_MOVE, SEARCH, COMMIT, CHECK_WIN, DONE.
- Reset, at any time including mid-turn or mid-handshake: state IDLE. Values after reset:
  - board all 0; cur_player 0; time_left 0; winner 0.
  - every pulse output, win_req, move_ready and game_over are 0.
  - LFSR is set to 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle, never stalls, and is never all-zero.
- IDLE or DONE with start=1: go to WAIT_MOVE. Clear board, set cur_player=1, set time_left=TURN_SECONDS, clear winner. start in any other state is ignored.
- WAIT_MOVE: move_ready=1. Rules in priority order:
  - move_req with move_pos<CELLS and that cell empty: latch the position, go to COMMIT with random_move=0.
  - move_req that is illegal (out of range or cell occupied): assert move_reject next cycle and stay in WAIT_MOVE. The timer is unaffected.
  - sec_tick with time_left>1: decrement time_left.
  - sec_tick with time_left==1: time_left=0, load the scan pointer, go to SEARCH.
    - Scan pointer = LFSR[PW-1:0], or 0 if that value is >= CELLS.
  - Same cycle, legal move_req plus expiring tick: the move wins and the timer is frozen.
  - Same cycle, illegal move_req plus expiring tick: reject and go to SEARCH.
- SEARCH: test one cell per cycle.
  - Empty cell: latch the pointer, go to COMMIT with random_move=1.
  - Occupied cell: advance the pointer, wrapping from CELLS-1 to 0.
  - An empty cell is guaranteed to exist because a full board ends the game first. SEARCH therefore takes at most CELLS cycles.
  - move_req is ignored in SEARCH.
- COMMIT, one cycle: placed=1 with placed_pos and random_move. At the end of the cycle, write cur_player into the cell. Go to CHECK_WIN.
- CHECK_WIN: win_req=1 until the first cycle with win_ack. On that cycle:
  - win_flag=1: winner=cur_player, go to DONE.
  - else, no empty cell left (post-write board): winner=0, go to DONE.
  - else: cur_player advances (N_PLAYERS wraps to 1), time_left=TURN_SECONDS, go to WAIT_MOVE.
  - win_ack outside CHECK_WIN is ignored.
- DONE: game_over=1. board, winner and cur_player hold until start.

## Timing
- All outputs are registered. Pulses last exactly one cycle.
- Legal move_req sampled at edge t:
  - placed high in cycle t+1.
  - board shows the new piece and win_req rises in cycle t+2.
- Illegal move_req sampled at edge t: move_reject high in cycle t+1. move_ready stays high.
- Expiring tick sampled at edge t: SEARCH begins in cycle t+1. placed rises k+1 cycles after SEARCH entry, where k is the number of occupied cells skipped.
- win_ack sampled at edge t: the new state is in effect in cycle t+1. This includes move_ready, the reloaded time_left, or game_over.
- Minimum turn: a 0-wait-state checker gives 3 cycles from move acceptance back to move_ready.

## Test plan
Bench defaults: N=2, CELLS=9, TURN_SECONDS=3.
- Reset mid-CHECK_WIN -> next cycle: IDLE, board=0, win_req=0, cur_player=0.
- Start, then P1 moves to pos 4 -> placed at t+1 with placed_pos=4, random_move=0. board[4]=1 at t+2. ack with win_flag=0 -> cur_player=2, time_left=3.
- Pos 4 again, or pos 9 -> move_reject pulse, board unchanged, still WAIT_MOVE.
- Three sec_ticks with cells 0..3 full and LFSR[3:0]=0 -> SEARCH skips 4 cells, commits pos 4 with random_move=1.
- P1 fills 0,1,2 with checker win_flag=1 on the third ack -> game_over=1, winner=1. A later move_req is ignored.
- Nine alternating moves, all acks with win_flag=0 -> game_over=1, winner=0. A start pulse then clears the board.
- Same cycle, legal move_req plus expiring tick -> user move committed, random_move=0.

Source files
------------

// File: rtl/game_turn_controller.sv
// Turn-based board controller for N players: timed turns, LFSR auto-play on
// timeout, tie detection, and win detection delegated over a req/ack handshake.
module game_turn_controller #(
  parameter  int N_PLAYERS    = 2,
  parameter  int CELLS        = 9,
  parameter  int TURN_SECONDS = 15,
  localparam int IDW = $clog2(N_PLAYERS + 1),
  localparam int PW  = ($clog2(CELLS) < 1) ? 1 : $clog2(CELLS),
  localparam int TW  = $clog2(TURN_SECONDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sec_tick,
  input  logic                 move_req,
  input  logic [PW-1:0]        move_pos,
  input  logic                 win_ack,
  input  logic                 win_flag,
  output logic                 move_ready,
  output logic                 move_reject,
  output logic                 placed,
  output logic [PW-1:0]        placed_pos,
  output logic                 random_move,
  output logic                 win_req,
  output logic [CELLS*IDW-1:0] board,
  output logic [IDW-1:0]       cur_player,
  output logic [TW-1:0]        time_left,
  output logic                 game_over,
  output logic [IDW-1:0]       winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SEARCH, S_COMMIT, S_CHECK, S_DONE
  } state_t;

  state_t               r_state, w_nstate;
  logic [15:0]          r_lfsr;
  logic [CELLS*IDW-1:0] r_board, w_board;
  logic [IDW-1:0]       r_cur, w_cur, r_winner, w_winner;
  logic [TW-1:0]        r_time, w_time;
  logic [PW-1:0]        r_ptr, w_ptr, w_seed;
  logic                 r_rand, w_rand;
  logic                 r_ready, r_reject, r_placed, r_win_req, r_over;
  logic                 w_reject, w_full, w_legal;
  logic [(1<<PW)-1:0]   w_empty;

  // Padding entries beyond CELLS read as occupied, so an out-of-range
  // move_pos is naturally illegal and the full test ignores them.
  for (genvar i = 0; i < (1 << PW); i++) begin : g_cell
    if (i < CELLS) begin : g_real
      assign w_empty[i] = (r_board[i*IDW +: IDW] == '0);
    end else begin : g_pad
      assign w_empty[i] = 1'b0;
    end
  end

  assign w_full  = ~|w_empty;
  assign w_legal = move_req & w_empty[move_pos];
  assign w_seed  = (32'(r_lfsr[PW-1:0]) < CELLS) ? r_lfsr[PW-1:0] : '0;

  always_comb begin
    w_nstate = r_state;
    w_board  = r_board;
    w_cur    = r_cur;
    w_winner = r_winner;
    w_time   = r_time;
    w_ptr    = r_ptr;
    w_rand   = r_rand;
    w_reject = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nstate = S_WAIT;
          w_board  = '0;
          w_cur    = IDW'(1);
          w_time   = TW'(TURN_SECONDS);
          w_winner = '0;
        end
      end
      S_WAIT: begin
        if (w_legal) begin
          w_ptr    = move_pos;
          w_rand   = 1'b0;
          w_nstate = S_COMMIT;
        end else begin
          // A refused move does not mask a tick arriving in the same cycle.
          w_reject = move_req;
          if (sec_tick) begin
            if (r_time > TW'(1)) begin
              w_time = r_time - TW'(1);
            end else begin
              w_time   = '0;
              w_ptr    = w_seed;
              w_nstate = S_SEARCH;
            end
          end
        end
      end
      S_SEARCH: begin
        if (w_empty[r_ptr]) begin
          w_rand   = 1'b1;
          w_nstate = S_COMMIT;
        end else begin
          w_ptr = (32'(r_ptr) == CELLS - 1) ? '0 : r_ptr + PW'(1);
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < CELLS; i++)
          if (r_ptr == PW'(i)) w_board[i*IDW +: IDW] = r_cur;
        w_nstate = S_CHECK;
      end
      S_CHECK: begin
        if (win_ack) begin
          if (win_flag) begin
            w_winner = r_cur;
            w_nstate = S_DONE;
          end else if (w_full) begin
            w_winner = '0;
            w_nstate = S_DONE;
          end else begin
            w_cur    = (32'(r_cur) == N_PLAYERS) ? IDW'(1) : r_cur + IDW'(1);
            w_time   = TW'(TURN_SECONDS);
            w_nstate = S_WAIT;
          end
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 16'hACE1;
      r_board   <= '0;
      r_cur     <= '0;
      r_winner  <= '0;
      r_time    <= '0;
      r_ptr     <= '0;
      r_rand    <= 1'b0;
      r_ready   <= 1'b0;
      r_reject  <= 1'b0;
      r_placed  <= 1'b0;
      r_win_req <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_lfsr    <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      r_board   <= w_board;
      r_cur     <= w_cur;
      r_winner  <= w_winner;
      r_time    <= w_time;
      r_ptr     <= w_ptr;
      r_rand    <= w_rand;
      r_ready   <= (w_nstate == S_WAIT);
      r_reject  <= w_reject;
      r_placed  <= (w_nstate == S_COMMIT);
      r_win_req <= (w_nstate == S_CHECK);
      r_over    <= (w_nstate == S_DONE);
    end
  end

  assign move_ready  = r_ready;
  assign move_reject = r_reject;
  assign placed      = r_placed;
  assign placed_pos  = r_ptr;
  assign random_move = r_rand;
  assign win_req     = r_win_req;
  assign board       = r_board;
  assign cur_player  = r_cur;
  assign time_left   = r_time;
  assign game_over   = r_over;
  assign winner      = r_winner;

endmodule

// File: tb/tb_game_turn_controller.sv
// Scoreboard bench for game_turn_controller: directed scenarios plus random
// games checked against a transaction-level model of the game rules.
module tb_game_turn_controller;
  localparam int N   = 2;
  localparam int C   = 9;
  localparam int TS  = 3;
  localparam int IDW = $clog2(N + 1);
  localparam int PW  = $clog2(C);
  localparam int TW  = $clog2(TS + 1);

  logic clk = 1'b0;
  logic rst, start, sec_tick, move_req, win_ack, win_flag;
  logic [PW-1:0] move_pos;
  logic move_ready, move_reject, placed, random_move, win_req, game_over;
  logic [PW-1:0] placed_pos;
  logic [C*IDW-1:0] board;
  logic [IDW-1:0] cur_player, winner;
  logic [TW-1:0] time_left;

  game_turn_controller #(.N_PLAYERS(N), .CELLS(C), .TURN_SECONDS(TS)) dut (
    .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick),
    .move_req(move_req), .move_pos(move_pos), .win_ack(win_ack), .win_flag(win_flag),
    .move_ready(move_ready), .move_reject(move_reject), .placed(placed),
    .placed_pos(placed_pos), .random_move(random_move), .win_req(win_req),
    .board(board), .cur_player(cur_player), .time_left(time_left),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: occupancy per cell, player to move, turn timer, LFSR.
  int          m_board[C];
  int          m_cur, m_time;
  bit          m_done;
  logic [15:0] m_lfsr;

  typedef struct { int pos; bit rnd; } place_t;
  place_t           q_place[$];
  int               q_rej[$];
  logic [C*IDW-1:0] q_board[$];
  int               q_cur[$];
  int               q_win[$];
  place_t           e;
  logic             wr_d = 1'b0, go_d = 1'b0;

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst) begin
      wr_d <= 1'b0;
      go_d <= 1'b0;
    end else begin
      if (placed) begin
        if (q_place.size() == 0) chk("unexpected_placed", placed, 0);
        else begin
          e = q_place.pop_front();
          chk("placed_pos", placed_pos, e.pos);
          chk("random_move", random_move, e.rnd);
        end
      end
      if (move_reject) begin
        if (q_rej.size() == 0) chk("unexpected_reject", move_reject, 0);
        else void'(q_rej.pop_front());
      end
      if (win_req && !wr_d) begin
        if (q_board.size() == 0) chk("unexpected_win_req", win_req, 0);
        else begin
          chk("board", board, q_board.pop_front());
          chk("cur_player", cur_player, q_cur.pop_front());
        end
      end
      if (game_over && !go_d) begin
        if (q_win.size() == 0) chk("unexpected_game_over", game_over, 0);
        else chk("winner", winner, q_win.pop_front());
      end
      wr_d <= win_req;
      go_d <= game_over;
    end
  end

  function automatic logic [C*IDW-1:0] pack();
    logic [C*IDW-1:0] v = '0;
    for (int i = 0; i < C; i++) v[i*IDW +: IDW] = IDW'(m_board[i]);
    return v;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < C; i++) if (m_board[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Random pick: start at the LFSR's low bits (0 if off-board), take the
  // first empty cell going upward with wrap; k counts occupied cells skipped.
  function automatic int predict(output int k);
    int p = int'(m_lfsr[PW-1:0]);
    if (p >= C) p = 0;
    k = 0;
    while (m_board[p] != 0 && k < C) begin
      p = (p + 1) % C;
      k++;
    end
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < C; i++) m_board[i] = 0;
    m_cur = 0; m_time = 0; m_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; sec_tick = 1'b0; move_req = 1'b0;
    move_pos = '0; win_ack = 1'b0; win_flag = 1'b0;
    @(negedge clk);
    chk("rst_board", board, 0);
    chk("rst_cur", cur_player, 0);
    chk("rst_time", time_left, 0);
    chk("rst_winner", winner, 0);
    chk("rst_win_req", win_req, 0);
    chk("rst_ready", move_ready, 0);
    chk("rst_over", game_over, 0);
    chk("rst_placed", placed, 0);
    chk("rst_reject", move_reject, 0);
    q_place.delete(); q_rej.delete(); q_board.delete(); q_cur.delete(); q_win.delete();
    model_clear();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    m_cur = 1; m_time = TS;
    chk("start_ready", move_ready, 1);
    chk("start_cur", cur_player, 1);
    chk("start_time", time_left, TS);
    chk("start_board", board, 0);
    chk("start_over", game_over, 0);
    chk("start_winner", winner, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!move_ready && n < 20) begin @(negedge clk); n++; end
    if (!move_ready) chk("ready_timeout", move_ready, 1);
  endtask

  // Called in the cycle placed is high; plays the win checker.
  task automatic finish_turn(input int pos, input bit flag);
    int n = 0;
    bit ended = 1'b0;
    m_board[pos] = m_cur;
    q_board.push_back(pack());
    q_cur.push_back(m_cur);
    while (!win_req && n < 4) begin @(negedge clk); n++; end
    chk("win_req_lat", n, 1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("win_req_hold", win_req, 1);
    win_ack = 1'b1; win_flag = flag;
    if (flag) begin q_win.push_back(m_cur); ended = 1'b1; end
    else if (m_full()) begin q_win.push_back(0); ended = 1'b1; end
    else begin m_cur = (m_cur == N) ? 1 : m_cur + 1; m_time = TS; end
    @(negedge clk);
    win_ack = 1'b0; win_flag = 1'b0;
    chk("ack_win_req_drop", win_req, 0);
    if (ended) begin
      m_done = 1'b1;
      chk("ack_over", game_over, 1);
      chk("ack_ready_low", move_ready, 0);
    end else begin
      chk("ack_ready", move_ready, 1);
      chk("ack_time", time_left, m_time);
      chk("ack_cur", cur_player, m_cur);
    end
  endtask

  // Called in the first SEARCH cycle; a move_req held throughout must be ignored.
  task automatic search_commit(input int rp, input int k, input bit flag);
    int n = 0;
    chk("search_not_ready", move_ready, 0);
    move_req = 1'b1; move_pos = PW'((rp + 1) % C);
    while (!placed && n < C + 2) begin @(negedge clk); n++; end
    move_req = 1'b0;
    chk("search_lat", n, k + 1);
    chk("auto_pos", placed_pos, rp);
    finish_turn(rp, flag);
  endtask

  task automatic user_move(input int pos, input bit flag, input bit with_tick);
    bit legal, expire;
    int rp, k;
    wait_ready();
    legal = (pos < C) && (m_board[pos] == 0);
    expire = 1'b0;
    move_req = 1'b1; move_pos = PW'(pos); sec_tick = with_tick;
    if (legal) q_place.push_back('{pos, 1'b0});
    else begin
      q_rej.push_back(pos);
      if (with_tick) begin
        if (m_time > 1) m_time--;
        else begin
          expire = 1'b1; m_time = 0;
          rp = predict(k);
          q_place.push_back('{rp, 1'b1});
        end
      end
    end
    @(negedge clk);
    move_req = 1'b0; sec_tick = 1'b0;
    chk("time_left", time_left, m_time);
    if (legal) begin
      chk("placed_lat", placed, 1);
      chk("ready_drop", move_ready, 0);
      finish_turn(pos, flag);
    end else begin
      chk("reject_lat", move_reject, 1);
      chk("board_kept", board, pack());
      if (expire) search_commit(rp, k, flag);
      else chk("ready_kept", move_ready, 1);
    end
  endtask

  task automatic tick(input bit flag);
    int rp, k;
    bit expire = 1'b0;
    wait_ready();
    sec_tick = 1'b1;
    if (m_time > 1) m_time--;
    else begin
      expire = 1'b1; m_time = 0;
      rp = predict(k);
      q_place.push_back('{rp, 1'b1});
    end
    @(negedge clk);
    sec_tick = 1'b0;
    chk("tick_time", time_left, m_time);
    if (expire) search_commit(rp, k, flag);
    else chk("tick_ready", move_ready, 1);
  endtask

  initial begin
    int n, r;
    do_reset();

    // First move, then occupied and off-board rejections.
    do_start();
    user_move(4, 1'b0, 1'b0);
    user_move(4, 1'b0, 1'b0);
    user_move(9, 1'b0, 1'b0);

    // Stray ack and stray start while waiting for a move.
    win_ack = 1'b1; win_flag = 1'b1; start = 1'b1;
    @(negedge clk);
    win_ack = 1'b0; win_flag = 1'b0; start = 1'b0;
    chk("stray_over", game_over, 0);
    chk("stray_ready", move_ready, 1);
    chk("stray_board", board, pack());
    chk("stray_cur", cur_player, m_cur);
    chk("stray_time", time_left, m_time);

    // Reset while the win check is outstanding.
    wait_ready();
    move_req = 1'b1; move_pos = '0;
    q_place.push_back('{0, 1'b0});
    @(negedge clk);
    move_req = 1'b0;
    m_board[0] = m_cur;
    q_board.push_back(pack());
    q_cur.push_back(m_cur);
    @(negedge clk);
    chk("pre_rst_win_req", win_req, 1);
    do_reset();

    // Cells 0..3 full, timeout with LFSR low bits 0: skip four, land on 4.
    do_start();
    for (int i = 0; i < 4; i++) user_move(i, 1'b0, 1'b0);
    tick(1'b0);
    tick(1'b0);
    n = 0;
    while (m_lfsr[PW-1:0] != '0 && n < 4000) begin @(negedge clk); n++; end
    tick(1'b0);

    // Player 1 wins on 0,1,2; later move is ignored.
    do_reset();
    do_start();
    user_move(0, 1'b0, 1'b0);
    user_move(3, 1'b0, 1'b0);
    user_move(1, 1'b0, 1'b0);
    user_move(4, 1'b0, 1'b0);
    user_move(2, 1'b1, 1'b0);
    chk("win_winner", winner, 1);
    move_req = 1'b1; move_pos = PW'(5);
    @(negedge clk);
    move_req = 1'b0;
    @(negedge clk);
    chk("done_board", board, pack());
    chk("done_over", game_over, 1);
    chk("done_cur", cur_player, 1);
    chk("done_placed", placed, 0);

    // Restart from DONE; nine moves with no winner is a tie.
    do_start();
    for (int i = 0; i < C; i++) user_move(i, 1'b0, 1'b0);
    chk("tie_over", game_over, 1);
    chk("tie_winner", winner, 0);
    do_start();

    // Legal move beats an expiring tick; illegal move plus expiry auto-plays.
    tick(1'b0);
    tick(1'b0);
    user_move(4, 1'b0, 1'b1);
    tick(1'b0);
    tick(1'b0);
    user_move(4, 1'b0, 1'b1);

    // Random games.
    for (int g = 0; g < 6; g++) begin
      do_reset();
      do_start();
      for (int t = 0; t < 60 && !m_done; t++) begin
        r = $urandom_range(0, 9);
        if (r < 6) user_move($urandom_range(0, C + 1), $urandom_range(0, 19) == 0,
                             $urandom_range(0, 3) == 0);
        else tick($urandom_range(0, 19) == 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("place_q_empty", q_place.size(), 0);
    chk("reject_q_empty", q_rej.size(), 0);
    chk("board_q_empty", q_board.size(), 0);
    chk("win_q_empty", q_win.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
